mux2x1_src_sequencer: RTL

//  Upstream control stage for the 4-bit 2:1 mux (A/B data, active-high disable en, sel).

---
 rtl/mux2x1_src_sequencer_if.sv | 25 ++
 rtl/mux2x1_src_sequencer.sv | 94 +++++++++
 2 files changed

// File: rtl/mux2x1_src_sequencer_if.sv
// Handshake and mux-drive bundle for mux2x1_src_sequencer.
// The master side feeds the source channels; the slave side is the sequencer.
interface mux2x1_src_sequencer_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] a_in;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_in;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             en;
  logic             sel;
  logic             busy;

  modport master (
    output a_in, a_valid, b_in, b_valid,
    input  a_ready, b_ready, A, B, en, sel, busy
  );

  modport slave (
    input  a_in, a_valid, b_in, b_valid,
    output a_ready, b_ready, A, B, en, sel, busy
  );
endinterface

// File: rtl/mux2x1_src_sequencer.sv
// Two-channel valid/ready arbiter that presents each granted word on a 2:1 mux for HOLD_CYCLES clocks.
// Define MUX_SEQ_FIXED_PRIO_EN for fixed A-over-B tie-break; default is round-robin.
module mux2x1_src_sequencer #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input logic                    clk,
  input logic                    rst,
  mux2x1_src_sequencer_if.slave  bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic             last;   // last granted channel: 0 = A, 1 = B
  logic [WIDTH-1:0] a_q, b_q;
  logic             en_q, sel_q, busy_q;
  logic             a_rdy, b_rdy;

  always_comb begin
    a_rdy = 1'b0;
    b_rdy = 1'b0;
    if (state == IDLE) begin
      if (bus.a_valid && bus.b_valid) begin
`ifdef MUX_SEQ_FIXED_PRIO_EN
        a_rdy = 1'b1;
`else
        // tie goes to whichever channel was not served last
        a_rdy = last;
        b_rdy = ~last;
`endif
      end else begin
        a_rdy = bus.a_valid;
        b_rdy = bus.b_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      en_q   <= 1'b1;
      sel_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt    <= 4'd0;
      last   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.a_valid && a_rdy) begin
            a_q    <= bus.a_in;
            sel_q  <= 1'b0;
            last   <= 1'b0;
            en_q   <= 1'b0;
            busy_q <= 1'b1;
            cnt    <= 4'(HOLD_CYCLES - 1);
            state  <= HOLD;
          end else if (bus.b_valid && b_rdy) begin
            b_q    <= bus.b_in;
            sel_q  <= 1'b1;
            last   <= 1'b1;
            en_q   <= 1'b0;
            busy_q <= 1'b1;
            cnt    <= 4'(HOLD_CYCLES - 1);
            state  <= HOLD;
          end
        end
        HOLD: begin
          // cnt reaching 0 ends the hold; it is only reloaded on accept, so it never wraps
          if (cnt == 4'd0) begin
            en_q   <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_ready = a_rdy;
  assign bus.b_ready = b_rdy;
  assign bus.A       = a_q;
  assign bus.B       = b_q;
  assign bus.en      = en_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;

endmodule
